// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending machine transaction sequencer
//
// Purpose: tracks coin credit in nickel units. It runs the dispense handshake
// with the product motor, then pays out change one coin per cycle. It also
// refunds the held credit on cancel or on an inactivity timeout.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   nickel, dime        coin inserted, one-cycle pulses
//   jolt, buzzWater     product selection, one-cycle pulses
//   cancel              coin-return button, one-cycle pulse
//   dispenseAck         motor done, only looked at in DISPENSE
//   dispenseJolt        Jolt motor request, held until ack
//   dispenseBuzzWater   BuzzWater motor request, held until ack
//   returnNickel        eject one nickel, one-cycle pulse
//   returnDime          eject one dime, one-cycle pulse
//   coinReject          route the current coin back, one-cycle pulse
//   busy                high in DISPENSE or CHANGE
//   credit              current credit in nickels
//   currentState        IDLE=000, CREDIT=001, DISPENSE=010, CHANGE=011

module vend_sequencer #(
  parameter int PRICE_JOLT = 4,
  parameter int PRICE_BW   = 4,
  parameter int CREDIT_MAX = 6,
  parameter int TIMEOUT    = 1000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            nickel,
  input  logic                            dime,
  input  logic                            jolt,
  input  logic                            buzzWater,
  input  logic                            cancel,
  input  logic                            dispenseAck,
  output logic                            dispenseJolt,
  output logic                            dispenseBuzzWater,
  output logic                            returnNickel,
  output logic                            returnDime,
  output logic                            coinReject,
  output logic                            busy,
  output logic [$clog2(CREDIT_MAX+1)-1:0] credit,
  output logic [2:0]                      currentState
);

  localparam int CW  = $clog2(CREDIT_MAX + 1);
  localparam int CW1 = CW + 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  // Credit arithmetic is done one bit wider so an over-limit sum is visible.
  localparam logic [CW:0]   CMAX = CW1'(CREDIT_MAX);
  localparam logic [CW:0]   PJ   = CW1'(PRICE_JOLT);
  localparam logic [CW:0]   PB   = CW1'(PRICE_BW);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_CREDIT   = 3'b001,
    S_DISPENSE = 3'b010,
    S_CHANGE   = 3'b011
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  credit_q, credit_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           disp_jolt_q, disp_jolt_d;
  logic           disp_bw_q, disp_bw_d;
  logic           ret_nickel_q, ret_nickel_d;
  logic           ret_dime_q, ret_dime_d;
  logic           reject_q, reject_d;
  logic           busy_q, busy_d;

  logic           coin_any;
  logic           coin_fits;
  logic [CW:0]    coin_val;
  logic [CW:0]    coin_sum;
  logic [CW:0]    sel_price;
  logic           sel_ok;
  logic [CW-1:0]  disp_price;
  logic [CW-1:0]  remain;

  always_comb begin
    // A coin is credited only when exactly one coin line is high and the
    // new total stays within CREDIT_MAX.
    coin_any  = nickel | dime;
    coin_val  = dime ? CW1'(2) : CW1'(1);
    coin_sum  = {1'b0, credit_q} + coin_val;
    coin_fits = coin_any && !(nickel && dime) && (coin_sum <= CMAX);

    // jolt wins when both selection pulses arrive together; affordability
    // is judged against the credit held before any coin of this cycle.
    sel_price = jolt ? PJ : PB;
    sel_ok    = (jolt | buzzWater) && ({1'b0, credit_q} >= sel_price);

    disp_price = disp_jolt_q ? PJ[CW-1:0] : PB[CW-1:0];
    remain     = credit_q - disp_price;

    state_d      = state_q;
    credit_d     = credit_q;
    timer_d      = '0;
    disp_jolt_d  = disp_jolt_q;
    disp_bw_d    = disp_bw_q;
    ret_nickel_d = 1'b0;
    ret_dime_d   = 1'b0;
    reject_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (coin_fits) begin
          credit_d = coin_sum[CW-1:0];
          state_d  = S_CREDIT;
        end
        reject_d = coin_any && !coin_fits;
      end

      S_CREDIT: begin
        if (cancel) begin
          if (coin_fits) credit_d = coin_sum[CW-1:0];
          reject_d = coin_any && !coin_fits;
          state_d  = S_CHANGE;
        end else if (sel_ok) begin
          // The coin is bounced so the price deducted later matches the
          // credit the customer saw when choosing.
          disp_jolt_d = jolt;
          disp_bw_d   = !jolt;
          reject_d    = coin_any;
          state_d     = S_DISPENSE;
        end else if (coin_fits) begin
          credit_d = coin_sum[CW-1:0];
        end else begin
          reject_d = coin_any;
          timer_d  = timer_q + TW'(1);
          if (timer_d == TMAX) state_d = S_CHANGE;
        end
      end

      S_DISPENSE: begin
        reject_d = coin_any;
        if (dispenseAck) begin
          disp_jolt_d = 1'b0;
          disp_bw_d   = 1'b0;
          credit_d    = remain;
          state_d     = (remain != '0) ? S_CHANGE : S_IDLE;
        end
      end

      S_CHANGE: begin
        reject_d = coin_any;
        if (credit_q >= CW'(2)) begin
          ret_dime_d = 1'b1;
          credit_d   = credit_q - CW'(2);
        end else if (credit_q == CW'(1)) begin
          ret_nickel_d = 1'b1;
          credit_d     = '0;
        end
        if (credit_d == '0) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      credit_q     <= '0;
      timer_q      <= '0;
      disp_jolt_q  <= 1'b0;
      disp_bw_q    <= 1'b0;
      ret_nickel_q <= 1'b0;
      ret_dime_q   <= 1'b0;
      reject_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      timer_q      <= timer_d;
      disp_jolt_q  <= disp_jolt_d;
      disp_bw_q    <= disp_bw_d;
      ret_nickel_q <= ret_nickel_d;
      ret_dime_q   <= ret_dime_d;
      reject_q     <= reject_d;
      busy_q       <= busy_d;
    end
  end

  assign dispenseJolt      = disp_jolt_q;
  assign dispenseBuzzWater = disp_bw_q;
  assign returnNickel      = ret_nickel_q;
  assign returnDime        = ret_dime_q;
  assign coinReject        = reject_q;
  assign busy              = busy_q;
  assign credit            = credit_q;
  assign currentState      = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed self-checking bench for vend_sequencer

module tb_vend_sequencer;

  localparam int N = 1, D = 2, J = 4, B = 8, C = 16, A = 32;
  localparam int ST_IDLE = 0, ST_CREDIT = 1, ST_DISP = 2, ST_CHANGE = 3;

  logic       clk = 1'b0;
  logic       rst_n, nickel, dime, jolt, buzzWater, cancel, dispenseAck;
  logic       dispenseJolt, dispenseBuzzWater, returnNickel, returnDime;
  logic       coinReject, busy;
  logic [2:0] credit;
  logic [2:0] currentState;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vend_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .nickel            (nickel),
    .dime              (dime),
    .jolt              (jolt),
    .buzzWater         (buzzWater),
    .cancel            (cancel),
    .dispenseAck       (dispenseAck),
    .dispenseJolt      (dispenseJolt),
    .dispenseBuzzWater (dispenseBuzzWater),
    .returnNickel      (returnNickel),
    .returnDime        (returnDime),
    .coinReject        (coinReject),
    .busy              (busy),
    .credit            (credit),
    .currentState      (currentState)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compares every output; busy follows from the expected state.
  task automatic expect_all(input string tag, input int st, input int cr, input int dj,
                            input int db, input int rn, input int rd, input int rj);
    check({tag, ".state"},  32'(currentState),      st);
    check({tag, ".credit"}, 32'(credit),            cr);
    check({tag, ".dj"},     32'(dispenseJolt),      dj);
    check({tag, ".dbw"},    32'(dispenseBuzzWater), db);
    check({tag, ".rn"},     32'(returnNickel),      rn);
    check({tag, ".rd"},     32'(returnDime),        rd);
    check({tag, ".rej"},    32'(coinReject),        rj);
    check({tag, ".busy"},   32'(busy),              (st == ST_DISP || st == ST_CHANGE) ? 1 : 0);
  endtask

  // Drive one cycle of inputs from a negedge, let one rising edge take them,
  // then return at the following negedge with inputs cleared.
  task automatic cyc(input int m);
    nickel      = m[0];
    dime        = m[1];
    jolt        = m[2];
    buzzWater   = m[3];
    cancel      = m[4];
    dispenseAck = m[5];
    @(posedge clk);
    @(negedge clk);
    nickel = 0; dime = 0; jolt = 0; buzzWater = 0; cancel = 0; dispenseAck = 0;
  endtask

  initial begin
    rst_n = 0; nickel = 0; dime = 0; jolt = 0; buzzWater = 0; cancel = 0; dispenseAck = 0;
    @(negedge clk);
    cyc(0);
    cyc(0);
    expect_all("reset", ST_IDLE, 0, 0, 0, 0, 0, 0);
    rst_n = 1;

    // Exact payment
    cyc(A);                   expect_all("ack_idle", ST_IDLE, 0, 0, 0, 0, 0, 0);
    cyc(N);                   expect_all("pay.n1", ST_CREDIT, 1, 0, 0, 0, 0, 0);
    cyc(N);                   expect_all("pay.n2", ST_CREDIT, 2, 0, 0, 0, 0, 0);
    cyc(D);                   expect_all("pay.d", ST_CREDIT, 4, 0, 0, 0, 0, 0);
    cyc(J);                   expect_all("pay.sel", ST_DISP, 4, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0);                 expect_all("pay.wait", ST_DISP, 4, 1, 0, 0, 0, 0);
    end
    cyc(A);                   expect_all("pay.ack", ST_IDLE, 0, 0, 0, 0, 0, 0);
    cyc(0);                   expect_all("pay.after", ST_IDLE, 0, 0, 0, 0, 0, 0);

    // Change after dispense, with a dime rejected during DISPENSE
    cyc(D);                   expect_all("chg.d1", ST_CREDIT, 2, 0, 0, 0, 0, 0);
    cyc(D);                   expect_all("chg.d2", ST_CREDIT, 4, 0, 0, 0, 0, 0);
    cyc(D);                   expect_all("chg.d3", ST_CREDIT, 6, 0, 0, 0, 0, 0);
    cyc(B);                   expect_all("chg.sel", ST_DISP, 6, 0, 1, 0, 0, 0);
    cyc(D);                   expect_all("chg.rejd", ST_DISP, 6, 0, 1, 0, 0, 1);
    cyc(0);                   expect_all("chg.rej_end", ST_DISP, 6, 0, 1, 0, 0, 0);
    cyc(A);                   expect_all("chg.ack", ST_CHANGE, 2, 0, 0, 0, 0, 0);
    cyc(A);                   expect_all("chg.dime", ST_IDLE, 0, 0, 0, 0, 1, 0);
    cyc(0);                   expect_all("chg.done", ST_IDLE, 0, 0, 0, 0, 0, 0);

    // Over-limit rejection at credit 6, then cancel refunds three dimes
    cyc(D); cyc(D); cyc(D);   expect_all("rej.six", ST_CREDIT, 6, 0, 0, 0, 0, 0);
    cyc(N);                   expect_all("rej.over", ST_CREDIT, 6, 0, 0, 0, 0, 1);
    cyc(0);                   expect_all("rej.pulse", ST_CREDIT, 6, 0, 0, 0, 0, 0);
    cyc(C);                   expect_all("can6", ST_CHANGE, 6, 0, 0, 0, 0, 0);
    cyc(0);                   expect_all("can6.d1", ST_CHANGE, 4, 0, 0, 0, 1, 0);
    cyc(0);                   expect_all("can6.d2", ST_CHANGE, 2, 0, 0, 0, 1, 0);
    cyc(0);                   expect_all("can6.d3", ST_IDLE, 0, 0, 0, 0, 1, 0);
    cyc(N | D);               expect_all("rej.both", ST_IDLE, 0, 0, 0, 0, 0, 1);
    cyc(C | J);               expect_all("idle.ign", ST_IDLE, 0, 0, 0, 0, 0, 0);

    // Timeout refund at credit 3
    cyc(N); cyc(D);           expect_all("to.three", ST_CREDIT, 3, 0, 0, 0, 0, 0);
    repeat (999) cyc(0);
    expect_all("to.before", ST_CREDIT, 3, 0, 0, 0, 0, 0);
    cyc(0);                   expect_all("to.expire", ST_CHANGE, 3, 0, 0, 0, 0, 0);
    cyc(0);                   expect_all("to.dime", ST_CHANGE, 1, 0, 0, 0, 1, 0);
    cyc(0);                   expect_all("to.nickel", ST_IDLE, 0, 0, 0, 1, 0, 0);

    // Cancel at credit 5
    cyc(D); cyc(D); cyc(N);   expect_all("can5", ST_CREDIT, 5, 0, 0, 0, 0, 0);
    cyc(C | J);               expect_all("can5.cancel", ST_CHANGE, 5, 0, 0, 0, 0, 0);
    cyc(0);                   expect_all("can5.d1", ST_CHANGE, 3, 0, 0, 0, 1, 0);
    cyc(0);                   expect_all("can5.d2", ST_CHANGE, 1, 0, 0, 0, 1, 0);
    cyc(0);                   expect_all("can5.n", ST_IDLE, 0, 0, 0, 1, 0, 0);

    // Selection rules
    cyc(N); cyc(D);           expect_all("sel.three", ST_CREDIT, 3, 0, 0, 0, 0, 0);
    cyc(J);                   expect_all("sel.short", ST_CREDIT, 3, 0, 0, 0, 0, 0);
    cyc(J | N);               expect_all("sel.short_coin", ST_CREDIT, 4, 0, 0, 0, 0, 0);
    cyc(J | B);               expect_all("sel.both", ST_DISP, 4, 1, 0, 0, 0, 0);
    cyc(A);                   expect_all("sel.both_ack", ST_IDLE, 0, 0, 0, 0, 0, 0);
    cyc(D); cyc(D);           expect_all("sel.four", ST_CREDIT, 4, 0, 0, 0, 0, 0);
    cyc(B | D);               expect_all("sel.coin_rej", ST_DISP, 4, 0, 1, 0, 0, 1);
    cyc(A);                   expect_all("sel.coin_ack", ST_IDLE, 0, 0, 0, 0, 0, 0);

    // Reset mid-dispense
    cyc(D); cyc(D); cyc(J);   expect_all("rst.disp", ST_DISP, 4, 1, 0, 0, 0, 0);
    rst_n = 0;
    cyc(0);                   expect_all("rst.mid", ST_IDLE, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    cyc(A);                   expect_all("rst.ack", ST_IDLE, 0, 0, 0, 0, 0, 0);
    cyc(0);                   expect_all("rst.after", ST_IDLE, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
